// File: rtl/fnd_ndigit_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_ndigit_scan_ctrl_pkg
//  Purpose  : Shared FND constants and the hex-to-segment lookup used by all
//             FND blocks. Segment order is {g,f,e,d,c,b,a}, active-low.
//  Revision : 1.0  initial release
// ============================================================================
package fnd_ndigit_scan_ctrl_pkg;

    // Whole digit dark, including the decimal point.
    localparam logic [7:0] c_seg_blank = 8'hFF;
    // g..a dark; used for leading-zero blanked digits whose DP may still light.
    localparam logic [6:0] c_seg_off   = 7'h7F;

    // Standard common-anode patterns for 0-9, A, b, C, d, E, F.
    function automatic logic [6:0] seg_lut(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_seg_decode
//  Purpose  : Combinational hex nibble to active-low 7-segment + DP decoder.
//  Ports    : i_hex   - nibble to display
//             i_blank - force g..a dark (DP still follows i_dp_on)
//             i_dp_on - light the decimal point
//             o_seg   - {dp,g,f,e,d,c,b,a}, active-low
//  Revision : 1.0  initial release
// ============================================================================
module fnd_seg_decode
    import fnd_ndigit_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_hex,
    input  logic       i_blank,
    input  logic       i_dp_on,
    output logic [7:0] o_seg
);

    logic [6:0] w_pat;

    assign w_pat = seg_lut(i_hex);
    assign o_seg = {~i_dp_on, (i_blank ? c_seg_off : w_pat)};

endmodule
`default_nettype wire

// File: rtl/fnd_ndigit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_ndigit_scan_ctrl
//  Purpose  : N-digit multiplexed common-anode FND scan controller with
//             tear-free frame latching, leading-zero blanking, per-digit DP
//             and blink, PWM brightness and an anti-ghost guard window.
//  Ports    : clk, reset_p (sync, active-high)
//             value/dp_en/blink_mask/blank_lz - latched once per frame
//             brightness - sampled live every cycle
//             com (active-low digit select), seg_7 (active-low {dp,g..a}),
//             frame_start (pulse when the digit-0 slot begins)
//  Revision : 1.0  initial release
// ============================================================================
module fnd_ndigit_scan_ctrl
    import fnd_ndigit_scan_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int GUARD     = 16,
    parameter int BR_W      = 3,
    parameter int BLINK_DIV = 250
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_en,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic                blank_lz,
    input  logic [BR_W-1:0]     brightness,
    output logic [DIGITS-1:0]   com,
    output logic [7:0]          seg_7,
    output logic                frame_start
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W  = $clog2(BLINK_DIV + 1);

    localparam logic [SLOT_W-1:0] c_slot_last  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] c_guard      = SLOT_W'(GUARD);
    localparam logic [IDX_W-1:0]  c_idx_last   = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0]  c_blink_last = BLK_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_first;       // first cycle after reset: load shadow
    logic [4*DIGITS-1:0] r_value_sh;
    logic [DIGITS-1:0]   r_dp_sh;
    logic [DIGITS-1:0]   r_blink_sh;
    logic                r_lz_sh;
    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_blink_on;
    logic [BR_W-1:0]     r_pwm_cnt;
    logic [DIGITS-1:0]   r_com;
    logic [7:0]          r_seg;
    logic                r_frame_start;

    logic              w_slot_wrap;
    logic              w_frame_wrap;
    logic              w_load;
    logic              w_pwm_on;
    logic              w_drive;
    logic [DIGITS-1:0] w_com_sel;
    logic [3:0]        w_nib;
    logic              w_dp;
    logic              w_bm;
    logic              w_lz;
    logic              w_zero_run;
    logic [7:0]        w_dec_seg;
    logic [7:0]        w_seg;

    assign w_slot_wrap  = (r_slot_cnt == c_slot_last);
    assign w_frame_wrap = w_slot_wrap && (r_idx == c_idx_last);
    assign w_load       = r_first || w_frame_wrap;

    assign w_pwm_on  = (brightness == '1) || (r_pwm_cnt < brightness);
    assign w_drive   = (r_slot_cnt >= c_guard) && w_pwm_on;
    assign w_com_sel = ~(DIGITS'(1) << r_idx);

    // Select the current digit's shadow fields. The zero run walks from the
    // leftmost digit, so a digit is blankable only while every digit to its
    // left is also zero; the rightmost digit always shows.
    always_comb begin
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_bm       = 1'b0;
        w_lz       = 1'b0;
        w_zero_run = r_lz_sh;
        for (int i = 0; i < DIGITS; i++) begin
            w_zero_run = w_zero_run && (r_value_sh[4*(DIGITS-1-i) +: 4] == 4'h0);
            if (IDX_W'(i) == r_idx) begin
                w_nib = r_value_sh[4*(DIGITS-1-i) +: 4];
                w_dp  = r_dp_sh[i];
                w_bm  = r_blink_sh[i];
                w_lz  = w_zero_run && (i != DIGITS - 1);
            end
        end
    end

    fnd_seg_decode u_dec (
        .i_hex   (w_nib),
        .i_blank (w_lz),
        .i_dp_on (w_dp),
        .o_seg   (w_dec_seg)
    );

    // Blink off-phase darkens the whole digit, DP included.
    assign w_seg = (!r_blink_on && w_bm) ? c_seg_blank : w_dec_seg;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_first       <= 1'b1;
            r_value_sh    <= '0;
            r_dp_sh       <= '0;
            r_blink_sh    <= '0;
            r_lz_sh       <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_on    <= 1'b1;
            r_pwm_cnt     <= '0;
            r_com         <= '1;
            r_seg         <= c_seg_blank;
            r_frame_start <= 1'b0;
        end else begin
            r_first   <= 1'b0;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;

            // The post-reset load cycle holds the prescaler so that frame 0
            // starts from slot 0 with valid shadow data, like every later frame.
            if (!r_first) begin
                if (w_slot_wrap) begin
                    r_slot_cnt <= '0;
                    r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                end else begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end
            end

            if (w_load) begin
                r_value_sh <= value;
                r_dp_sh    <= dp_en;
                r_blink_sh <= blink_mask;
                r_lz_sh    <= blank_lz;
            end

            if (w_frame_wrap) begin
                if (r_blink_cnt == c_blink_last) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end

            r_frame_start <= w_load;
            if (r_first) begin
                r_com <= '1;
                r_seg <= c_seg_blank;
            end else begin
                r_com <= w_drive ? w_com_sel : '1;
                r_seg <= w_seg;
            end
        end
    end

    assign com         = r_com;
    assign seg_7       = r_seg;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_fnd_ndigit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_ndigit_scan_ctrl
//  Purpose  : Self-checking bench for fnd_ndigit_scan_ctrl (4 digits, 8-cycle
//             slots, 2-cycle guard, 2-bit brightness, 2-frame blink).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fnd_ndigit_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int GUARD     = 2;
    localparam int BR_W      = 2;
    localparam int BLINK_DIV = 2;
    localparam int NT        = 11;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [3:0]  com;
    logic [7:0]  seg_7;
    logic        frame_start;

    always #5 clk = ~clk;

    fnd_ndigit_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BR_W      (BR_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .value       (value),
        .dp_en       (dp_en),
        .blink_mask  (blink_mask),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .com         (com),
        .seg_7       (seg_7),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  bm;
        logic        lz;
        logic [1:0]  br;
    } cfg_t;

    typedef struct {
        logic [7:0] seg;
        int         low;
    } exp_t;

    cfg_t tbl [NT];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Active-low {dp,g..a} with DP off.
    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input cfg_t c, input int d, input bit on);
        logic [15:0] left;
        logic [3:0]  nib;
        logic [7:0]  s;
        logic        blank;
        left  = c.v >> (4 * (3 - d));       // digits 0..d
        nib   = left[3:0];
        blank = c.lz && (d != 3) && (left == 16'h0);
        if (!on && c.bm[d]) return 8'hFF;
        s    = blank ? 8'hFF : lut[nib];
        s[7] = ~c.dp[d];
        return s;
    endfunction

    // Com-low pins of every slot line up with pwm_cnt values 3,0,1,2,3,0
    // because the PWM counter and the scan both restart at reset.
    function automatic int exp_low(input logic [1:0] br);
        int n = 0;
        if (br == 2'b11) return 6;
        for (int j = 0; j < 6; j++)
            if (((3 + j) % 4) < br) n++;
        return n;
    endfunction

    task automatic apply_cfg(input int f);
        value      = tbl[f].v;
        dp_en      = tbl[f].dp;
        blink_mask = tbl[f].bm;
        blank_lz   = tbl[f].lz;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 40);
    endtask

    // Entered on the negedge where frame_start is high for frame 'first'.
    task automatic run_frames(input int first, input int nfr);
        for (int k = 0; k < nfr; k++) begin
            int  f;
            bit  on;
            f          = first + k;
            on         = ((k / BLINK_DIV) % 2) == 0;
            brightness = tbl[f].br;
            for (int d = 0; d < 4; d++)
                sb_q.push_back('{exp_seg(tbl[f], d, on), exp_low(tbl[f].br)});
            for (int d = 0; d < 4; d++) begin
                logic [7:0] seg0;
                int lows, bad, unstable, fs_hi;
                exp_t e;
                seg0 = 8'h00; lows = 0; bad = 0; unstable = 0; fs_hi = 0;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (c == 0) seg0 = seg_7;
                    else if (seg_7 !== seg0) unstable++;
                    if (com !== 4'hF) begin
                        if (c < GUARD || com !== ~(4'b0001 << d)) bad++;
                        else lows++;
                    end
                    if (frame_start && !(d == 3 && c == 7)) fs_hi++;
                    // Change the next frame's data mid-frame (during idx 2).
                    if (d == 2 && c == 0 && f + 1 < NT) apply_cfg(f + 1);
                end
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("seg f%0d d%0d", f, d), seg0, e.seg);
                    check($sformatf("com_low f%0d d%0d", f, d), lows, e.low);
                end
                check($sformatf("seg_hold f%0d d%0d", f, d), unstable, 0);
                check($sformatf("com_shape f%0d d%0d", f, d), bad, 0);
                check($sformatf("fs_extra f%0d d%0d", f, d), fs_hi, 0);
            end
            check($sformatf("fs_pulse f%0d", f), frame_start, 1);
        end
    endtask

    initial begin
        int n;
        tbl[0]  = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, 2'd3};
        tbl[1]  = '{16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd3};
        tbl[2]  = '{16'h2222, 4'b0000, 4'b0000, 1'b0, 2'd1};
        tbl[3]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3};
        tbl[4]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd0};
        tbl[5]  = '{16'h0000, 4'b0100, 4'b0001, 1'b1, 2'd2};
        tbl[6]  = '{16'h1234, 4'b0100, 4'b0001, 1'b0, 2'd3};
        tbl[7]  = '{16'h1234, 4'b0100, 4'b0001, 1'b0, 2'd3};
        tbl[8]  = '{16'h1234, 4'b0100, 4'b0001, 1'b0, 2'd3};
        tbl[9]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3};
        tbl[10] = '{16'h9876, 4'b0000, 4'b1111, 1'b1, 2'd3};

        reset_p = 1'b1;
        apply_cfg(0);
        brightness = tbl[0].br;
        repeat (3) @(negedge clk);
        check("rst_com", com, 4'hF);
        check("rst_seg", seg_7, 8'hFF);
        check("rst_fs", frame_start, 0);
        reset_p = 1'b0;

        wait_fs(n);
        check("fs_first_latency", n, 1);
        check("load_com", com, 4'hF);
        check("load_seg", seg_7, 8'hFF);

        run_frames(0, 9);

        // Frame 9 (pre-reset): move into the idx-2 slot, then reset mid-slot.
        repeat (20) @(negedge clk);
        check("pre_rst_com", com, 4'b1011);
        reset_p = 1'b1;
        @(negedge clk);
        check("midrst_com", com, 4'hF);
        check("midrst_seg", seg_7, 8'hFF);
        check("midrst_fs", frame_start, 0);
        reset_p = 1'b0;
        wait_fs(n);
        check("fs_restart_latency", n, 1);

        run_frames(9, 2);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
